rb_unpack: RTL and testbench
============================

RB_UNPACK -- requirements
Module: rb_unpack

Interface
REQ-001 SHALL have parameter BEATS, default 4, words per cache line (power of 2, 2..16).
REQ-002 SHALL have parameter CNTW, default 16, error counter width.
REQ-003 Rclk  in  1  single clock; all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 RD  in  144  read-buffer head word (FWFT); bits [63:0] and [127:64] are data, [143:128] are check bits.
REQ-006 Empty  in  1  read buffer empty; RD and error flags are invalid when high.
REQ-007 SingleError  in  1  corrected single-bit error on current head word.
REQ-008 DoubleError  in  1  uncorrectable error on current head word.
REQ-009 RDen  out  1  pop read buffer head this cycle.
REQ-010 DataOut  out  128  user data beat, {RD[127:64], RD[63:0]}.
REQ-011 DataValid  out  1  DataOut holds a beat.
REQ-012 DataReady  in  1  user accepts the beat when DataValid && DataReady.
REQ-013 BeatIdx  out  log2(BEATS)  index of current beat within its line.
REQ-014 LastBeat  out  1  current beat is BEATS-1.
REQ-015 LineDErr  out  1  on the LastBeat beat only: some beat of this line had DoubleError.
REQ-016 SECount, DECount  out  CNTW each  saturating single/double error totals.

Function
REQ-017 RDen SHALL equal !Empty && (!DataValid || DataReady), combinational; never asserted while Empty is high.
REQ-018 On RDen, the next cycle SHALL present DataOut = RD data bits and DataValid = 1 (latency one cycle); check bits are discarded.
REQ-019 DataValid SHALL clear after a handshake when no pop occurred in the same cycle; back-to-back pops SHALL sustain one beat per cycle.
REQ-020 DataOut, BeatIdx, LastBeat, LineDErr SHALL hold stable while DataValid && !DataReady.
REQ-021 Beat counter SHALL increment on each pop and wrap from BEATS-1 to 0; BeatIdx is the counter value captured with the beat.
REQ-022 Line state: IDLE (counter 0, no sticky error) -> INLINE on pop of beat 0 -> back to IDLE on pop of beat BEATS-1; for BEATS=2 and above, states are encoded by the counter plus sticky bit.
REQ-023 Sticky double-error bit SHALL set on any popped word with DoubleError, be ORed into LineDErr of the last beat, and clear when the last beat is popped.
REQ-024 On a popped word, DoubleError SHALL increment DECount only; SingleError without DoubleError SHALL increment SECount; both high counts as double only.
REQ-025 Counters SHALL saturate at all-ones and never wrap.
REQ-026 Error flags SHALL be sampled only in pop cycles; flags while Empty or stalled are ignored.

Reset
REQ-027 On Reset: DataValid=0, DataOut=0, BeatIdx=0, LastBeat=0, LineDErr=0, counter=0, sticky=0, SECount=0, DECount=0; RDen=0 during the Reset cycle.
REQ-028 Reset mid-line SHALL discard the partial line; the first pop after Reset is beat 0.

Structure
REQ-029 Shared package SHALL hold RB_WORD_W=144, RB_DATA_W=128, and the data/check bit-field ranges.
REQ-030 One sub-module sat_counter (width CNTW, inc, clear) SHALL be instantiated twice for SECount/DECount.

Verification
REQ-031 4 words A,B,C,D, Empty low, DataReady=1 -> RDen high 4 consecutive cycles; DataValid beats 0..3 cycle after each pop, LastBeat on D, LineDErr=0.
REQ-032 DataReady=0 for 3 cycles with beat 1 held -> RDen=0, DataOut/BeatIdx unchanged; resume -> no loss, no duplicate.
REQ-033 DoubleError on beat 1 of line, SingleError+DoubleError on beat 2 -> DECount=2, SECount=0, LineDErr=1 on beat 3 only; next line LineDErr=0.
REQ-034 CNTW=4, 20 single-error words -> SECount stops at 15.
REQ-035 Reset after 2 beats of a line -> all outputs 0; next pop shows BeatIdx=0.
REQ-036 Empty high with SingleError=1 -> RDen=0, SECount unchanged.

Source files
------------

// File: rtl/rb_unpack_pkg.sv
// Shared widths and bit-field ranges of the 144-bit read-buffer word.
package rb_unpack_pkg;

    localparam int unsigned RB_WORD_W  = 144;
    localparam int unsigned RB_DATA_W  = 128;

    // Two 64-bit data halves followed by the check bits.
    localparam int unsigned RB_LO_LSB  = 0;
    localparam int unsigned RB_LO_MSB  = 63;
    localparam int unsigned RB_HI_LSB  = 64;
    localparam int unsigned RB_HI_MSB  = 127;
    localparam int unsigned RB_CHK_LSB = 128;
    localparam int unsigned RB_CHK_MSB = 143;

endpackage

// File: rtl/rb_unpack_if.sv
// Read-buffer side and user-beat side of the unpacker, bundled as one interface.
interface rb_unpack_if #(
    parameter int unsigned BEATS = 4
);
    import rb_unpack_pkg::*;

    localparam int unsigned IW = $clog2(BEATS);

    logic [RB_WORD_W-1:0] RD;
    logic                 Empty;
    logic                 SingleError;
    logic                 DoubleError;
    logic                 RDen;
    logic [RB_DATA_W-1:0] DataOut;
    logic                 DataValid;
    logic                 DataReady;
    logic [IW-1:0]        BeatIdx;
    logic                 LastBeat;
    logic                 LineDErr;

    // Environment side: owns the read buffer and the user consumer.
    modport master (
        output RD, Empty, SingleError, DoubleError, DataReady,
        input  RDen, DataOut, DataValid, BeatIdx, LastBeat, LineDErr
    );

    // Unpacker side.
    modport slave (
        input  RD, Empty, SingleError, DoubleError, DataReady,
        output RDen, DataOut, DataValid, BeatIdx, LastBeat, LineDErr
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Count register, synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/rb_unpack.sv
// Pops ECC-checked words from a FWFT read buffer and presents them as indexed
// line beats with a one-deep output register, per-line double-error flag and
// saturating error totals.
module rb_unpack
    import rb_unpack_pkg::*;
#(
    parameter int unsigned BEATS = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic            Rclk,
    input  logic            Reset,
    rb_unpack_if.slave      bus,
    output logic [CNTW-1:0] SECount,
    output logic [CNTW-1:0] DECount
);

    localparam int unsigned IW = $clog2(BEATS);

    logic                 pop;
    logic                 at_last;
    logic [RB_DATA_W-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic [IW-1:0]        beat_idx_q, beat_idx_d;
    logic                 last_q, last_d;
    logic                 lderr_q, lderr_d;
    // Line position; together with sticky_q this is the whole line state
    // (counter 0 and no sticky = idle, anything else = inside a line).
    logic [IW-1:0]        cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;

    // Check bits are already consumed by the buffer's ECC logic.
    logic                 unused_chk;
    assign unused_chk = ^bus.RD[RB_CHK_MSB:RB_CHK_LSB];

    // Pop whenever the output register is free or being drained this cycle.
    assign pop      = !Reset && !bus.Empty && (!valid_q || bus.DataReady);
    assign bus.RDen = pop;
    assign at_last  = (cnt_q == IW'(BEATS - 1));

    // Next-state: capture a beat on pop, otherwise drop valid after handshake.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        beat_idx_d = beat_idx_q;
        last_d     = last_q;
        lderr_d    = lderr_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        if (pop) begin
            data_d     = {bus.RD[RB_HI_MSB:RB_HI_LSB], bus.RD[RB_LO_MSB:RB_LO_LSB]};
            valid_d    = 1'b1;
            beat_idx_d = cnt_q;
            last_d     = at_last;
            lderr_d    = at_last && (sticky_q || bus.DoubleError);
            // BEATS is a power of two, so the increment wraps naturally.
            cnt_d      = cnt_q + IW'(1);
            sticky_d   = !at_last && (sticky_q || bus.DoubleError);
        end else if (valid_q && bus.DataReady) begin
            valid_d    = 1'b0;
        end
    end

    // Output beat register and line state.
    always_ff @(posedge Rclk) begin
        if (Reset) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            beat_idx_q <= '0;
            last_q     <= 1'b0;
            lderr_q    <= 1'b0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            beat_idx_q <= beat_idx_d;
            last_q     <= last_d;
            lderr_q    <= lderr_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.DataOut   = data_q;
    assign bus.DataValid = valid_q;
    assign bus.BeatIdx   = beat_idx_q;
    assign bus.LastBeat  = last_q;
    assign bus.LineDErr  = lderr_q;

    // A double error dominates: both flags high counts as double only.
    sat_counter #(
        .Width (CNTW)
    ) u_se_cnt (
        .clk_i   (Rclk),
        .clear_i (Reset),
        .inc_i   (pop && bus.SingleError && !bus.DoubleError),
        .count_o (SECount)
    );

    sat_counter #(
        .Width (CNTW)
    ) u_de_cnt (
        .clk_i   (Rclk),
        .clear_i (Reset),
        .inc_i   (pop && bus.DoubleError),
        .count_o (DECount)
    );

endmodule

// File: tb/tb_rb_unpack.sv
// Bench for rb_unpack: a queue-based read-buffer model feeds the DUT and a
// line/beat reference model predicts every output each cycle.
module tb_rb_unpack;

    localparam int unsigned BEATS = 4;
    localparam int unsigned CNTW  = 4;
    localparam int          CMAX  = (1 << CNTW) - 1;

    typedef struct {
        logic [143:0] w;
        bit           se;
        bit           de;
    } word_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [CNTW-1:0] se_count;
    logic [CNTW-1:0] de_count;

    always #5 clk = ~clk;

    rb_unpack_if #(.BEATS(BEATS)) bus ();

    rb_unpack #(
        .BEATS (BEATS),
        .CNTW  (CNTW)
    ) dut (
        .Rclk    (clk),
        .Reset   (rst),
        .bus     (bus),
        .SECount (se_count),
        .DECount (de_count)
    );

    int checks = 0;
    int errors = 0;

    // Read-buffer contents and stimulus knobs.
    word_t q[$];
    bit    gap     = 1'b0;
    bit    idle_se = 1'b0;

    // Reference model: what the user should be looking at.
    bit           m_valid;
    logic [127:0] m_data;
    int           m_idx;
    bit           m_last;
    bit           m_lderr;
    int           m_pops;      // words popped since reset
    bit           m_line_de;   // any double error in the current line so far
    int           m_se;
    int           m_de;
    bit           exp_rden;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] rand_word();
        logic [159:0] t;
        for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
        return t[143:0];
    endfunction

    task automatic push(input bit se, input bit de);
        word_t w;
        w.w  = rand_word();
        w.se = se;
        w.de = de;
        q.push_back(w);
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_idx     = 0;
        m_last    = 1'b0;
        m_lderr   = 1'b0;
        m_pops    = 0;
        m_line_de = 1'b0;
        m_se      = 0;
        m_de      = 0;
    endtask

    task automatic drive();
        if (q.size() == 0 || gap) begin
            bus.Empty       = 1'b1;
            bus.RD          = rand_word();
            bus.SingleError = idle_se ? 1'b1 : 1'($urandom % 2);
            bus.DoubleError = idle_se ? 1'b0 : 1'($urandom % 2);
        end else begin
            bus.Empty       = 1'b0;
            bus.RD          = q[0].w;
            bus.SingleError = q[0].se;
            bus.DoubleError = q[0].de;
        end
    endtask

    // One clock: drive after negedge, check RDen, advance model at posedge,
    // check registered outputs 1 time unit later.
    task automatic cycle();
        word_t w;
        drive();
        #1;
        exp_rden = !rst && !bus.Empty && (!m_valid || bus.DataReady);
        chk("rden", 144'(bus.RDen), 144'(exp_rden));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (exp_rden) begin
            w        = q.pop_front();
            m_data   = w.w[127:0];
            m_valid  = 1'b1;
            m_idx    = m_pops % BEATS;
            m_last   = (m_idx == BEATS - 1);
            m_line_de = m_line_de || w.de;
            m_lderr  = m_last && m_line_de;
            if (m_last) m_line_de = 1'b0;
            m_pops++;
            if (w.de) m_de = (m_de < CMAX) ? m_de + 1 : CMAX;
            else if (w.se) m_se = (m_se < CMAX) ? m_se + 1 : CMAX;
        end else if (m_valid && bus.DataReady) begin
            m_valid = 1'b0;
        end
        #1;
        chk("valid",   144'(bus.DataValid), 144'(m_valid));
        chk("data",    144'(bus.DataOut),   144'(m_data));
        chk("beatidx", 144'(bus.BeatIdx),   144'(m_idx));
        chk("last",    144'(bus.LastBeat),  144'(m_last));
        chk("lineder", 144'(bus.LineDErr),  144'(m_lderr));
        chk("secount", 144'(se_count),      144'(m_se));
        chk("decount", 144'(de_count),      144'(m_de));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.DataReady   = 1'b0;
        bus.Empty       = 1'b1;
        bus.RD          = '0;
        bus.SingleError = 1'b0;
        bus.DoubleError = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state, buffer empty.
        run(2);
        rst = 1'b0;

        // Four clean words streamed back to back.
        bus.DataReady = 1'b1;
        repeat (4) push(1'b0, 1'b0);
        run(6);

        // Consumer stalls for three cycles while beat 1 is held.
        repeat (4) push(1'b0, 1'b0);
        run(2);
        bus.DataReady = 1'b0;
        run(3);
        bus.DataReady = 1'b1;
        run(5);

        // Double error on beat 1, both flags on beat 2, then a clean line.
        push(1'b0, 1'b0);
        push(1'b0, 1'b1);
        push(1'b1, 1'b1);
        push(1'b0, 1'b0);
        repeat (4) push(1'b0, 1'b0);
        run(10);
        chk("de_total", 144'(de_count), 144'(2));
        chk("se_total", 144'(se_count), 144'(0));

        // Single-error counter saturation.
        do_reset();
        repeat (20) push(1'b1, 1'b0);
        run(24);
        chk("se_sat", 144'(se_count), 144'(CMAX));

        // Reset after two beats of a line; buffer keeps its remaining words.
        do_reset();
        repeat (4) push(1'b0, 1'b0);
        run(2);
        do_reset();
        run(4);
        repeat (2) push(1'b0, 1'b0);
        run(4);

        // Error flags while empty are ignored.
        idle_se = 1'b1;
        run(4);
        idle_se = 1'b0;

        // Randomized traffic with gaps, back-pressure and rare resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 3 != 0) push(($urandom % 3) == 0, ($urandom % 5) == 0);
            gap           = ($urandom % 4) == 0;
            bus.DataReady = ($urandom % 4) != 0;
            rst           = ($urandom % 97) == 0;
            cycle();
        end
        rst           = 1'b0;
        gap           = 1'b0;
        bus.DataReady = 1'b1;
        for (int i = 0; i < 300 && (q.size() != 0 || m_valid); i++) cycle();
        chk("drained", 144'(q.size()), 144'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
